// File: rtl/dma_mc.sv
// Multi-channel DMA engine. NCH channels, each programmed through four io
// registers, move words between data RAM and the io bus in round-robin
// bursts. Destination writes trail source reads by RD_LAT cycles through
// a shift pipeline. A maskable, level-sensitive done interrupt is raised
// per channel. Register reads that do not hit this block pass through
// unchanged from io_rdata_in.
module dma_mc #(
    parameter int          NCH      = 2,
    parameter int          DATA_W   = 16,
    parameter int          MEM_AW   = 12,
    parameter int          CNT_W    = 13,
    parameter int          BURST    = 8,
    parameter int          RD_LAT   = 2,
    parameter logic [13:0] REG_BASE = 14'h3FE0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rst_pipe,
    input  logic              io_we,
    input  logic [13:0]       io_wadr,
    input  logic [DATA_W-1:0] io_wdata,
    input  logic [13:0]       io_radr,
    input  logic [DATA_W-1:0] io_rdata_in,
    output logic [DATA_W-1:0] io_rdata,
    output logic              dma_re_ma,
    output logic [13:0]       dataram_radr_ma,
    input  logic [DATA_W-1:0] dataram_rdata_wb,
    output logic              dma_we_ma,
    output logic [13:0]       dataram_wadr_ma,
    output logic [DATA_W-1:0] dataram_wdata_ma,
    output logic              ibus_ren,
    output logic [13:0]       ibus_radr,
    input  logic [DATA_W-1:0] ibus_rdata,
    output logic              ibus_wen,
    output logic [13:0]       ibus_wadr,
    output logic [DATA_W-1:0] ibus_wdata,
    output logic              dma_busy,
    output logic              dma_irq
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int WW = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

    logic [13:0]       ioadr_q  [NCH];
    logic [13:0]       ioadr_d  [NCH];
    logic [MEM_AW-1:0] memadr_q [NCH];
    logic [MEM_AW-1:0] memadr_d [NCH];
    logic [CNT_W-1:0]  count_q  [NCH];
    logic [CNT_W-1:0]  count_d  [NCH];
    logic [NCH-1:0]    irq_en_q, irq_en_d, done_q, done_d;
    logic [NCH-1:0]    rd_run_q, rd_run_d, wr_run_q, wr_run_d, run_s;

    state_t            state_q, state_d;
    logic [CW-1:0]     cur_q, cur_d, last_q, last_d, pick_s;
    logic              pick_ok_s, issue_s, exit_s;
    logic [CNT_W-1:0]  beats_q, beats_d, idx_q, idx_d;
    logic [WW-1:0]     wait_q, wait_d;

    logic [13:0]       iss_io_s;
    logic [MEM_AW-1:0] iss_mem_s;
    logic              iss_dir_s;

    logic              pv_q   [RD_LAT];
    logic              pdir_q [RD_LAT];
    logic [13:0]       pio_q  [RD_LAT];
    logic [MEM_AW-1:0] pmem_q [RD_LAT];
    logic [DATA_W-1:0] ramdat_q;
    logic [13:0]       radr_q;

    logic [13:0]       woff_s, roff_s;
    logic              wr_hit_s, rd_hit_s;
    logic [CW-1:0]     wch_s, rch_s;
    logic              unused_s;

    // Register-block decode for the write and (registered) read addresses
    assign woff_s   = io_wadr - REG_BASE;
    assign wr_hit_s = io_we && (woff_s < 14'(4 * NCH));
    assign wch_s    = woff_s[CW+1:2];
    assign roff_s   = radr_q - REG_BASE;
    assign rd_hit_s = roff_s < 14'(4 * NCH);
    assign rch_s    = roff_s[CW+1:2];
    assign unused_s = ^{io_wdata[DATA_W-1:14]};
    assign run_s    = rd_run_q | wr_run_q;

    // Round-robin search for the next pending channel after the last one served
    always_comb begin
        pick_s    = last_q;
        pick_ok_s = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            if (!pick_ok_s && run_s[(int'(last_q) + k) % NCH]) begin
                pick_s    = CW'((int'(last_q) + k) % NCH);
                pick_ok_s = 1'b1;
            end else begin
                pick_ok_s = pick_ok_s;
            end
        end
    end

    // Transfer FSM: grant, issue one source read per cycle, then drain the pipeline
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        beats_d = beats_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        issue_s = 1'b0;
        exit_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_ok_s) begin
                    cur_d   = pick_s;
                    last_d  = pick_s;
                    beats_d = (count_q[pick_s] < CNT_W'(BURST)) ? count_q[pick_s] : CNT_W'(BURST);
                    idx_d   = CNT_W'(0);
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                issue_s = 1'b1;
                idx_d   = idx_q + CNT_W'(1);
                if (idx_q + CNT_W'(1) == beats_q) begin
                    wait_d  = WW'(0);
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                wait_d = wait_q + WW'(1);
                if (wait_q == WW'(RD_LAT - 1)) begin
                    exit_s  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Source address of the beat issued this cycle; wr_run means mem->io
    assign iss_io_s  = ioadr_q[cur_q] + 14'(idx_q);
    assign iss_mem_s = memadr_q[cur_q] + MEM_AW'(idx_q);
    assign iss_dir_s = wr_run_q[cur_q];

    // Channel register next-state: end-of-burst advance first, then io writes
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            ioadr_d[c]  = ioadr_q[c];
            memadr_d[c] = memadr_q[c];
            count_d[c]  = count_q[c];
            irq_en_d[c] = irq_en_q[c];
            done_d[c]   = done_q[c];
            rd_run_d[c] = rd_run_q[c];
            wr_run_d[c] = wr_run_q[c];
            if (exit_s && (cur_q == CW'(c))) begin
                ioadr_d[c]  = ioadr_q[c] + 14'(beats_q);
                memadr_d[c] = memadr_q[c] + MEM_AW'(beats_q);
                count_d[c]  = count_q[c] - beats_q;
                if (count_q[c] == beats_q) begin
                    rd_run_d[c] = 1'b0;
                    wr_run_d[c] = 1'b0;
                    done_d[c]   = 1'b1;
                end else begin
                    done_d[c] = done_q[c];
                end
            end else begin
                count_d[c] = count_q[c];
            end
            if (wr_hit_s && (wch_s == CW'(c))) begin
                case (woff_s[1:0])
                    2'd0: begin
                        irq_en_d[c] = io_wdata[2];
                        if (io_wdata[3]) begin
                            done_d[c] = 1'b0;
                        end else begin
                            done_d[c] = done_d[c];
                        end
                        if (!run_s[c] && (io_wdata[1:0] == 2'b01 || io_wdata[1:0] == 2'b10)) begin
                            if (count_q[c] == CNT_W'(0)) begin
                                done_d[c] = 1'b1;
                            end else begin
                                rd_run_d[c] = io_wdata[0];
                                wr_run_d[c] = io_wdata[1];
                            end
                        end else begin
                            rd_run_d[c] = rd_run_d[c];
                        end
                    end
                    2'd1: ioadr_d[c]  = run_s[c] ? ioadr_q[c]  : io_wdata[13:0];
                    2'd2: memadr_d[c] = run_s[c] ? memadr_q[c] : io_wdata[MEM_AW-1:0];
                    2'd3: count_d[c]  = run_s[c] ? count_q[c]  : io_wdata[CNT_W-1:0];
                    default: ioadr_d[c] = ioadr_d[c];
                endcase
            end else begin
                irq_en_d[c] = irq_en_d[c];
            end
        end
    end

    // All state registers; rst_pipe aborts everything including in-flight beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || rst_pipe) begin
            for (int c = 0; c < NCH; c++) begin
                ioadr_q[c]  <= 14'd0;
                memadr_q[c] <= MEM_AW'(0);
                count_q[c]  <= CNT_W'(0);
            end
            for (int s = 0; s < RD_LAT; s++) begin
                pv_q[s]   <= 1'b0;
                pdir_q[s] <= 1'b0;
                pio_q[s]  <= 14'd0;
                pmem_q[s] <= MEM_AW'(0);
            end
            irq_en_q <= {NCH{1'b0}};
            done_q   <= {NCH{1'b0}};
            rd_run_q <= {NCH{1'b0}};
            wr_run_q <= {NCH{1'b0}};
            state_q  <= S_IDLE;
            cur_q    <= CW'(0);
            last_q   <= CW'(NCH - 1);
            beats_q  <= CNT_W'(0);
            idx_q    <= CNT_W'(0);
            wait_q   <= WW'(0);
            ramdat_q <= DATA_W'(0);
            radr_q   <= 14'd0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                ioadr_q[c]  <= ioadr_d[c];
                memadr_q[c] <= memadr_d[c];
                count_q[c]  <= count_d[c];
            end
            pv_q[0]   <= issue_s;
            pdir_q[0] <= iss_dir_s;
            pio_q[0]  <= iss_io_s;
            pmem_q[0] <= iss_mem_s;
            for (int s = 1; s < RD_LAT; s++) begin
                pv_q[s]   <= pv_q[s-1];
                pdir_q[s] <= pdir_q[s-1];
                pio_q[s]  <= pio_q[s-1];
                pmem_q[s] <= pmem_q[s-1];
            end
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            rd_run_q <= rd_run_d;
            wr_run_q <= wr_run_d;
            state_q  <= state_d;
            cur_q    <= cur_d;
            last_q   <= last_d;
            beats_q  <= beats_d;
            idx_q    <= idx_d;
            wait_q   <= wait_d;
            ramdat_q <= dataram_rdata_wb;
            radr_q   <= io_radr;
        end
    end

    // Source side comes straight from FSM state, destination side from the pipeline tail
    assign ibus_ren         = issue_s & ~iss_dir_s;
    assign ibus_radr        = ibus_ren ? iss_io_s : 14'd0;
    assign dma_re_ma        = issue_s & iss_dir_s;
    assign dataram_radr_ma  = dma_re_ma ? 14'(iss_mem_s) : 14'd0;
    assign dma_we_ma        = pv_q[RD_LAT-1] & ~pdir_q[RD_LAT-1];
    assign dataram_wadr_ma  = dma_we_ma ? 14'(pmem_q[RD_LAT-1]) : 14'd0;
    assign dataram_wdata_ma = ibus_rdata;
    assign ibus_wen         = pv_q[RD_LAT-1] & pdir_q[RD_LAT-1];
    assign ibus_wadr        = ibus_wen ? pio_q[RD_LAT-1] : 14'd0;
    assign ibus_wdata       = ramdat_q;
    assign dma_busy         = |run_s;
    assign dma_irq          = |(done_q & irq_en_q);

    // Read-back mux: channel register on a hit, otherwise downstream data
    always_comb begin
        io_rdata = io_rdata_in;
        if (rd_hit_s) begin
            case (roff_s[1:0])
                2'd0: io_rdata = DATA_W'({done_q[rch_s], irq_en_q[rch_s], wr_run_q[rch_s], rd_run_q[rch_s]});
                2'd1: io_rdata = DATA_W'(ioadr_q[rch_s]);
                2'd2: io_rdata = DATA_W'(memadr_q[rch_s]);
                2'd3: io_rdata = DATA_W'(count_q[rch_s]);
                default: io_rdata = io_rdata_in;
            endcase
        end else begin
            io_rdata = io_rdata_in;
        end
    end
endmodule
